// File: rtl/conv_tile_sched.sv
// conv_tile_sched: feeds one channel at a time (5x5 map + 25 weights) to a
// single conv engine, accumulates the nine engine results across channels
// with saturating signed adds, and hands out one 3x3 tile per group.
module conv_tile_sched #(
  parameter int NBITS   = 16,
  parameter int ACCW    = NBITS + 4,
  parameter int MAX_CH  = 16,
  parameter int TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [25*NBITS-1:0]   in_map,
  input  logic [25*NBITS-1:0]   in_wgt,
  input  logic                  in_last,
  output logic                  cv_start,
  output logic [25*NBITS-1:0]   cv_map,
  output logic [25*NBITS-1:0]   cv_wgt,
  input  logic [9*NBITS-1:0]    cv_out,
  input  logic                  cv_valid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [9*ACCW-1:0]     out_map,
  output logic [4:0]            out_nch,
  output logic                  out_sat,
  output logic                  err_tmo
);

  localparam int WCW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_EMIT   = 2'd3
  } state_t;

  state_t               state_r, state_nxt;
  logic [WCW-1:0]       wait_cnt_r, wait_nxt;
  logic [4:0]           ch_cnt_r, ch_nxt;
  logic [9*ACCW-1:0]    acc_r, acc_nxt;
  logic                 sat_r, sat_nxt;
  logic                 err_tmo_r, tmo_nxt;
  logic                 in_last_r;
  logic                 cap_s;
  logic [ACCW:0]        add_s;
  logic                 in_ready_r, cv_start_r, out_valid_r, out_sat_r;
  logic [25*NBITS-1:0]  cv_map_r, cv_wgt_r;
  logic [9*ACCW-1:0]    out_map_r;
  logic [4:0]           out_nch_r;

  // Signed add of a sign-extended engine lane into an accumulator lane.
  // Returns {clamped, result}; overflow shows as a carry/sign disagreement.
  function automatic logic [ACCW:0] sat_add(input logic [ACCW-1:0] a,
                                             input logic [NBITS-1:0] b);
    logic [ACCW:0] s;
    s = {a[ACCW-1], a} + {{(ACCW+1-NBITS){b[NBITS-1]}}, b};
    if (s[ACCW] == s[ACCW-1]) begin
      sat_add = {1'b0, s[ACCW-1:0]};
    end else if (s[ACCW] == 1'b0) begin
      sat_add = {1'b1, 1'b0, {(ACCW-1){1'b1}}};
    end else begin
      sat_add = {1'b1, 1'b1, {(ACCW-1){1'b0}}};
    end
  endfunction

  // Next-state, counters and accumulator update for the channel sequencer.
  always_comb begin
    state_nxt = state_r;
    wait_nxt  = wait_cnt_r;
    ch_nxt    = ch_cnt_r;
    acc_nxt   = acc_r;
    sat_nxt   = sat_r;
    tmo_nxt   = err_tmo_r;
    cap_s     = 1'b0;
    add_s     = {(ACCW+1){1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (in_valid && in_ready_r) begin
          cap_s     = 1'b1;
          state_nxt = ST_LAUNCH;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        wait_nxt  = {WCW{1'b0}};
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // A result arriving on the timeout cycle still counts.
        if (cv_valid) begin
          for (int i = 0; i < 9; i++) begin
            add_s = sat_add((ch_cnt_r == 5'd0) ? {ACCW{1'b0}} : acc_r[i*ACCW +: ACCW],
                            cv_out[i*NBITS +: NBITS]);
            acc_nxt[i*ACCW +: ACCW] = add_s[ACCW-1:0];
            sat_nxt = sat_nxt | add_s[ACCW];
          end
          ch_nxt = ch_cnt_r + 5'd1;
          if (in_last_r || (ch_nxt == 5'(MAX_CH))) begin
            state_nxt = ST_EMIT;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (wait_cnt_r == WCW'(TIMEOUT)) begin
          // Engine went silent: drop the partial tile and flag it.
          tmo_nxt   = 1'b1;
          acc_nxt   = {(9*ACCW){1'b0}};
          ch_nxt    = 5'd0;
          sat_nxt   = 1'b0;
          state_nxt = ST_IDLE;
        end else begin
          wait_nxt  = wait_cnt_r + WCW'(1'b1);
          state_nxt = ST_WAIT;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          acc_nxt   = {(9*ACCW){1'b0}};
          ch_nxt    = 5'd0;
          sat_nxt   = 1'b0;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_EMIT;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; outputs decode the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      wait_cnt_r  <= {WCW{1'b0}};
      ch_cnt_r    <= 5'd0;
      acc_r       <= {(9*ACCW){1'b0}};
      sat_r       <= 1'b0;
      err_tmo_r   <= 1'b0;
      in_last_r   <= 1'b0;
      cv_map_r    <= {(25*NBITS){1'b0}};
      cv_wgt_r    <= {(25*NBITS){1'b0}};
      in_ready_r  <= 1'b0;
      cv_start_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_map_r   <= {(9*ACCW){1'b0}};
      out_nch_r   <= 5'd0;
      out_sat_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      wait_cnt_r  <= wait_nxt;
      ch_cnt_r    <= ch_nxt;
      acc_r       <= acc_nxt;
      sat_r       <= sat_nxt;
      err_tmo_r   <= tmo_nxt;
      if (cap_s) begin
        cv_map_r  <= in_map;
        cv_wgt_r  <= in_wgt;
        in_last_r <= in_last;
      end
      in_ready_r  <= (state_nxt == ST_IDLE);
      cv_start_r  <= (state_nxt == ST_LAUNCH);
      out_valid_r <= (state_nxt == ST_EMIT);
      out_map_r   <= (state_nxt == ST_EMIT) ? acc_nxt : {(9*ACCW){1'b0}};
      out_nch_r   <= (state_nxt == ST_EMIT) ? ch_nxt : 5'd0;
      out_sat_r   <= (state_nxt == ST_EMIT) ? sat_nxt : 1'b0;
    end
  end

  assign in_ready  = in_ready_r;
  assign cv_start  = cv_start_r;
  assign cv_map    = cv_map_r;
  assign cv_wgt    = cv_wgt_r;
  assign out_valid = out_valid_r;
  assign out_map   = out_map_r;
  assign out_nch   = out_nch_r;
  assign out_sat   = out_sat_r;
  assign err_tmo   = err_tmo_r;

endmodule

// File: tb/tb_conv_tile_sched.sv
// Directed bench for conv_tile_sched with a stub engine and a tile scoreboard.
module tb_conv_tile_sched;
  localparam int NB = 16;
  localparam int AW = 18;
  localparam int MC = 16;
  localparam int TO = 64;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [25*NB-1:0]   in_map;
  logic [25*NB-1:0]   in_wgt;
  logic               in_last;
  logic               cv_start;
  logic [25*NB-1:0]   cv_map;
  logic [25*NB-1:0]   cv_wgt;
  logic [9*NB-1:0]    cv_out;
  logic               cv_valid = 1'b0;
  logic               out_valid;
  logic               out_ready;
  logic [9*AW-1:0]    out_map;
  logic [4:0]         out_nch;
  logic               out_sat;
  logic               err_tmo;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [9*AW-1:0] map;
    logic [4:0]      nch;
    logic            sat;
  } exp_t;
  exp_t sb_q[$];

  int eng_lat    = 3;
  bit eng_silent = 1'b0;
  int eng_cnt    = 0;
  int eng_lane[9];

  conv_tile_sched #(.NBITS(NB), .ACCW(AW), .MAX_CH(MC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_map(in_map), .in_wgt(in_wgt), .in_last(in_last),
    .cv_start(cv_start), .cv_map(cv_map), .cv_wgt(cv_wgt),
    .cv_out(cv_out), .cv_valid(cv_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_map(out_map),
    .out_nch(out_nch), .out_sat(out_sat), .err_tmo(err_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub engine: answers eng_lat cycles after a launch pulse unless silenced.
  always @(negedge clk) begin
    cv_valid = 1'b0;
    if (cv_start === 1'b1 && !eng_silent) begin
      eng_cnt = eng_lat;
    end else if (eng_cnt > 0) begin
      eng_cnt = eng_cnt - 1;
      if (eng_cnt == 0) cv_valid = 1'b1;
    end
  end

  // Engine result lanes follow the per-lane table.
  always_comb begin
    cv_out = '0;
    for (int i = 0; i < 9; i++) begin
      cv_out[i*NB +: NB] = eng_lane[i][NB-1:0];
    end
  end

  task automatic check(input string tag, input logic [399:0] obs, input logic [399:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: saturating sum of nch identical engine results.
  task automatic push_exp(input int nch);
    exp_t e;
    int a[9];
    int t;
    int hi;
    int lo;
    hi = (1 << (AW-1)) - 1;
    lo = -(1 << (AW-1));
    e.sat = 1'b0;
    for (int i = 0; i < 9; i++) a[i] = 0;
    for (int c = 0; c < nch; c++) begin
      for (int i = 0; i < 9; i++) begin
        a[i] = a[i] + eng_lane[i];
        if (a[i] > hi) begin a[i] = hi; e.sat = 1'b1; end
        if (a[i] < lo) begin a[i] = lo; e.sat = 1'b1; end
      end
    end
    for (int i = 0; i < 9; i++) begin
      t = a[i];
      e.map[i*AW +: AW] = t[AW-1:0];
    end
    e.nch = 5'(nch);
    sb_q.push_back(e);
  endtask

  task automatic set_lanes(input int base, input int step);
    for (int i = 0; i < 9; i++) eng_lane[i] = base + step * i;
  endtask

  task automatic send_ch(input bit last);
    int t;
    logic [25*NB-1:0] m;
    logic [25*NB-1:0] w;
    t = 0;
    @(negedge clk);
    for (int i = 0; i < 25; i++) begin
      m[i*NB +: NB] = NB'($urandom);
      w[i*NB +: NB] = NB'($urandom);
    end
    in_map = m; in_wgt = w; in_last = last; in_valid = 1'b1;
    while (in_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    check("in_ready_accept", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    check("cv_start", cv_start, 1'b1);
    check("cv_map", cv_map, m);
    check("cv_wgt", cv_wgt, w);
    check("in_ready_busy", in_ready, 1'b0);
  endtask

  task automatic wait_tile(input int hold);
    int t;
    exp_t e;
    t = 0;
    while (out_valid !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    check("out_valid", out_valid, 1'b1);
    e = sb_q.pop_front();
    check("out_map", out_map, e.map);
    check("out_nch", out_nch, e.nch);
    check("out_sat", out_sat, e.sat);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1'b1);
      check("hold_map", out_map, e.map);
      check("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("rel_valid", out_valid, 1'b0);
    check("rel_map", out_map, '0);
    check("rel_nch", out_nch, 5'd0);
    check("rel_in_ready", in_ready, 1'b1);
  endtask

  task automatic run_tile(input int nch, input bit use_last, input int hold);
    push_exp(nch);
    for (int c = 0; c < nch; c++) send_ch(use_last && (c == nch - 1));
    wait_tile(hold);
  endtask

  initial begin
    int n;
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_map = '0; in_wgt = '0;
    set_lanes(0, 0);
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_cv_start", cv_start, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_map", out_map, '0);
    check("rst_cv_map", cv_map, '0);
    check("rst_err_tmo", err_tmo, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1'b1);

    // T1: lanes i+1, three channels closed by in_last
    set_lanes(1, 1);
    run_tile(3, 1'b1, 0);
    // T2: positive clamp at ACCW=18, then a non-clamping tile clears sat
    set_lanes(32767, 0);
    run_tile(5, 1'b1, 0);
    eng_lat = 1;
    run_tile(3, 1'b1, 0);
    // negative clamp boundary
    set_lanes(-32768, 0);
    run_tile(5, 1'b1, 0);
    // T3: forced emit at MAX_CH without in_last
    eng_lat = 2;
    set_lanes(1, 0);
    run_tile(16, 1'b0, 0);
    // T5: back-pressure on the output for 10 cycles, mixed signs
    set_lanes(-4000, 1000);
    run_tile(2, 1'b1, 10);

    // T4: one good channel, then a silent engine on the second
    set_lanes(7, 0);
    send_ch(1'b0);
    @(negedge clk);
    eng_silent = 1'b1;
    send_ch(1'b1);
    n = 0;
    while (err_tmo !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("tmo_cycles", n, 66);
    check("tmo_in_ready", in_ready, 1'b1);
    check("tmo_out_valid", out_valid, 1'b0);
    eng_silent = 1'b0;
    set_lanes(5, 0);
    run_tile(1, 1'b1, 0);
    check("tmo_sticky", err_tmo, 1'b1);

    // T6: reset during WAIT, engine answers afterwards
    eng_lat = 6;
    set_lanes(9, 0);
    send_ch(1'b1);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_rst_in_ready", in_ready, 1'b0);
    check("t6_rst_cv_map", cv_map, '0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_out_map", out_map, '0);
    check("t6_err_tmo", err_tmo, 1'b0);
    check("t6_in_ready", in_ready, 1'b1);
    check("t6_cv_start", cv_start, 1'b0);
    eng_lat = 2;
    set_lanes(4, 0);
    run_tile(1, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
